mul_share_sequencer: RTL

Two-client round-robin arbiter and sequencer for the CPU's shared 16x16 unsigned multiplier cell. It accepts 32x32 unsigned multiply requests from two requesters and issues up to four 16x16 partial products to the external cell. It accumulates the returned products into a 64-bit sum and returns either the low or the high 32 bits. It sits between the CPU mul/custom-instruction ports and the single multiplier cell, so that two masters share one DSP resource.

---
 rtl/mul_share_sequencer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/mul_share_sequencer.sv
// mul_share_sequencer
// Two-client round-robin front end for one shared 16x16 unsigned multiplier
// cell. A 32x32 request becomes three or four 16x16 partial products. They
// are accumulated into a 64-bit sum, and the requested 32-bit half is
// returned as a one-cycle response pulse.
//
// Handshake: a request transfers on a rising edge where reqN_valid and
// reqN_ready are both high. ready is only offered in IDLE to the granted
// client, and only while that client is valid. The client holds valid and
// its operands until the transfer. resp_valid has no backpressure.
module mul_share_sequencer #(
    parameter int MUL_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_hi,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_hi,
    output logic        resp_valid,
    output logic        resp_id,
    output logic [31:0] resp_data,
    output logic [15:0] mul_a,
    output logic [15:0] mul_b,
    input  logic [31:0] mul_p,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE0 = 3'd1,
        S_ISSUE1 = 3'd2,
        S_ISSUE2 = 3'd3,
        S_ISSUE3 = 3'd4,
        S_DRAIN  = 3'd5
    } state_t;

    // shift encodes the left shift in units of 16 bits (0, 16 or 32)
    typedef struct packed {
        logic       valid;
        logic [1:0] shift;
        logic       last;
    } tag_t;

    state_t      state, state_next;
    logic        grant;
    logic        prio;
    logic        hs;
    logic [31:0] op_a, op_b;
    logic        op_hi, op_id;
    logic [63:0] acc;
    logic [63:0] term;
    logic [63:0] sum;
    logic [5:0]  shift_amt;
    tag_t        tag_in;
    tag_t        tag_out;
    tag_t        tag_pipe [MUL_LATENCY];

    assign dbg_state = state;
    assign tag_out   = tag_pipe[MUL_LATENCY-1];

    // Arbitration: a lone valid client wins; on a tie the preferred client wins
    always_comb begin
        grant = prio;
        if (req0_valid && !req1_valid)
            grant = 1'b0;
        else if (req1_valid && !req0_valid)
            grant = 1'b1;
    end

    assign req0_ready = (state == S_IDLE) && !reset && req0_valid && !grant;
    assign req1_ready = (state == S_IDLE) && !reset && req1_valid && grant;
    assign hs         = req0_ready || req1_ready;

    // Partial-product term aligned to its weight, and the running sum
    assign shift_amt = {tag_out.shift, 4'b0000};
    assign term      = {32'h0, mul_p} << shift_amt;
    assign sum       = acc + term;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (hs) state_next = S_ISSUE0;
            S_ISSUE0: state_next = S_ISSUE1;
            S_ISSUE1: state_next = S_ISSUE2;
            S_ISSUE2: state_next = op_hi ? S_ISSUE3 : S_DRAIN;
            S_ISSUE3: state_next = S_DRAIN;
            S_DRAIN:  if (tag_out.valid && tag_out.last) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // FSM outputs: operand halves to the cell and the tag for each issue.
    // The hi*hi term is skipped for low-half requests, so ISSUE2 ends them.
    always_comb begin
        mul_a        = 16'h0;
        mul_b        = 16'h0;
        tag_in.valid = 1'b0;
        tag_in.shift = 2'd0;
        tag_in.last  = 1'b0;
        case (state)
            S_ISSUE0: begin
                mul_a        = op_a[15:0];
                mul_b        = op_b[15:0];
                tag_in.valid = 1'b1;
            end
            S_ISSUE1: begin
                mul_a        = op_a[31:16];
                mul_b        = op_b[15:0];
                tag_in.valid = 1'b1;
                tag_in.shift = 2'd1;
            end
            S_ISSUE2: begin
                mul_a        = op_a[15:0];
                mul_b        = op_b[31:16];
                tag_in.valid = 1'b1;
                tag_in.shift = 2'd1;
                tag_in.last  = !op_hi;
            end
            S_ISSUE3: begin
                mul_a        = op_a[31:16];
                mul_b        = op_b[31:16];
                tag_in.valid = 1'b1;
                tag_in.shift = 2'd2;
                tag_in.last  = 1'b1;
            end
            default: ;
        endcase
    end

    // Tag pipe tracking the cell latency; clearing it drops in-flight products
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MUL_LATENCY; i++)
                tag_pipe[i] <= '0;
        end else begin
            tag_pipe[0] <= tag_in;
            for (int i = 1; i < MUL_LATENCY; i++)
                tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    // Latch the accepted request and move the round-robin preference
    always_ff @(posedge clk) begin
        if (reset) begin
            op_a  <= '0;
            op_b  <= '0;
            op_hi <= 1'b0;
            op_id <= 1'b0;
            prio  <= 1'b0;
        end else if (hs) begin
            op_a  <= grant ? req1_a : req0_a;
            op_b  <= grant ? req1_b : req0_b;
            op_hi <= grant ? req1_hi : req0_hi;
            op_id <= grant;
            prio  <= !grant;
        end
    end

    // Accumulator: cleared on acceptance, adds each returning term
    always_ff @(posedge clk) begin
        if (reset)
            acc <= '0;
        else if (hs)
            acc <= '0;
        else if (tag_out.valid)
            acc <= sum;
    end

    // Response register: pulse on the last term, data and id held afterwards
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_data  <= '0;
        end else begin
            resp_valid <= tag_out.valid && tag_out.last;
            if (tag_out.valid && tag_out.last) begin
                resp_id   <= op_id;
                resp_data <= op_hi ? sum[63:32] : sum[31:0];
            end
        end
    end

endmodule
